kbd_scan_ctrl: RTL

//  Sequences the raw PS/2 byte stream from the keyboard receiver into make/break key

---
 rtl/kbd_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/kbd_scan_ctrl.sv
// PS/2 scan-byte sequencer: make/break event FIFO, held-key display gating and a BCD press counter.
// Optional macro TYPEMATIC_FILTER_EN suppresses repeated makes of the currently held key.
module kbd_scan_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_overflow,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_make,
    output logic       ev_drop,
    output logic       disp_en,
    output logic [7:0] disp_code,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] B_BRK = 8'hF0;
    localparam logic [7:0] B_EXT = 8'hE0;

    // Keyboard status/ack bytes that never form part of a key sequence.
    function automatic logic is_status(input logic [7:0] b);
        logic r;
        case (b)
            8'hFA, 8'hAA, 8'hEE, 8'h00, 8'hFF: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = v[3:0];
        tens = v[7:4];
        if (ones == 4'd9) begin
            ones = 4'd0;
            if (tens == 4'd9) begin
                tens = 4'd0;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    state_t state_q, state_d;

    logic       ev_gen_s;
    logic       ev_mk_s;
    logic       ev_ext_s;
    logic       typematic_s;
    logic       make_acc_s;
    logic       brk_match_s;
    logic       push_req_s;

    logic       held_vld_q, held_vld_d;
    logic [8:0] held_q, held_d;
    logic       disp_en_q, disp_en_d;
    logic [7:0] disp_code_q, disp_code_d;
    logic [7:0] press_cnt_q, press_cnt_d;

    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [PTR_W:0]   cnt_after_pop_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [9:0]       new_entry_s;
    logic [9:0]       head_q, head_d;
    logic             ev_valid_q, ev_valid_d;
    logic             ev_drop_q, ev_drop_d;

    // Sequencer state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state; an overflow always aborts back to IDLE.
    always_comb begin
        state_d = state_q;
        if (rx_overflow) begin
            state_d = ST_IDLE;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == B_BRK) begin
                        state_d = ST_BRK;
                    end else if (rx_data == B_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (rx_data == B_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_data == B_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: state_d = ST_IDLE;
                default:            state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Sequencer outputs: which byte completes a make or break event.
    always_comb begin
        ev_gen_s = 1'b0;
        ev_mk_s  = 1'b0;
        ev_ext_s = 1'b0;
        if (rx_valid && !rx_overflow) begin
            case (state_q)
                ST_IDLE: begin
                    if ((rx_data != B_BRK) && (rx_data != B_EXT) && !is_status(rx_data)) begin
                        ev_gen_s = 1'b1;
                        ev_mk_s  = 1'b1;
                    end else begin
                        ev_gen_s = 1'b0;
                    end
                end
                ST_BRK: begin
                    ev_gen_s = (rx_data != B_BRK) && (rx_data != B_EXT);
                end
                ST_EXT: begin
                    ev_gen_s = (rx_data != B_BRK) && (rx_data != B_EXT);
                    ev_mk_s  = 1'b1;
                    ev_ext_s = 1'b1;
                end
                ST_EXT_BRK: begin
                    ev_gen_s = (rx_data != B_BRK) && (rx_data != B_EXT);
                    ev_ext_s = 1'b1;
                end
                default: ev_gen_s = 1'b0;
            endcase
        end else begin
            ev_gen_s = 1'b0;
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    assign typematic_s = ev_mk_s && held_vld_q && (held_q == {ev_ext_s, rx_data});
`else
    assign typematic_s = 1'b0;
`endif

    assign make_acc_s  = ev_gen_s && ev_mk_s && !typematic_s;
    assign brk_match_s = ev_gen_s && !ev_mk_s && held_vld_q && (held_q == {ev_ext_s, rx_data});
    assign push_req_s  = make_acc_s || (ev_gen_s && !ev_mk_s);

    // Held-key tracking, display and press counter next state.
    always_comb begin
        held_vld_d  = held_vld_q;
        held_d      = held_q;
        disp_en_d   = disp_en_q;
        disp_code_d = disp_code_q;
        press_cnt_d = press_cnt_q;
        if (make_acc_s) begin
            held_vld_d  = 1'b1;
            held_d      = {ev_ext_s, rx_data};
            disp_en_d   = 1'b1;
            disp_code_d = rx_data;
            press_cnt_d = bcd_inc(press_cnt_q);
        end else if (brk_match_s) begin
            held_vld_d = 1'b0;
            disp_en_d  = 1'b0;
        end else begin
            held_vld_d = held_vld_q;
        end
    end

    // Held-key and display registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_vld_q  <= 1'b0;
            held_q      <= 9'd0;
            disp_en_q   <= 1'b0;
            disp_code_q <= 8'd0;
            press_cnt_q <= 8'h00;
        end else begin
            held_vld_q  <= held_vld_d;
            held_q      <= held_d;
            disp_en_q   <= disp_en_d;
            disp_code_q <= disp_code_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign full_s      = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
    assign pop_s       = ev_valid_q && ev_ready;
    assign push_s      = push_req_s && (!full_s || pop_s);
    assign drop_s      = push_req_s && full_s && !pop_s;
    assign new_entry_s = {ev_ext_s, ev_mk_s, rx_data};

    // FIFO pointers, occupancy and the fall-through head for the registered outputs.
    always_comb begin
        wr_ptr_d        = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d        = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        cnt_after_pop_s = cnt_q - (PTR_W+1)'(pop_s);
        cnt_d           = cnt_after_pop_s + (PTR_W+1)'(push_s);
        ev_valid_d      = (cnt_d != (PTR_W+1)'(0));
        ev_drop_d       = drop_s;
        // A push into an otherwise empty FIFO lands directly on the head.
        if (push_s && (cnt_after_pop_s == (PTR_W+1)'(0))) begin
            head_d = new_entry_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // FIFO storage and registered head outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 10'd0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            head_q     <= 10'd0;
            ev_valid_q <= 1'b0;
            ev_drop_q  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= new_entry_s;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            ev_valid_q <= ev_valid_d;
            ev_drop_q  <= ev_drop_d;
        end
    end

    assign ev_valid  = ev_valid_q;
    assign ev_ext    = head_q[9];
    assign ev_make   = head_q[8];
    assign ev_code   = head_q[7:0];
    assign ev_drop   = ev_drop_q;
    assign disp_en   = disp_en_q;
    assign disp_code = disp_code_q;
    assign press_cnt = press_cnt_q;

endmodule
